// File: rtl/ctrl_pkg.sv
// Shared encodings for the rysyCore multi-cycle control unit: opcodes,
// func fields, datapath select encodings and the sequencing FSM states.
package ctrl_pkg;

    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam int F7_ALT_BIT = 5;

    localparam logic [1:0] INST_HOLD = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_NOP  = 2'b10;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_XOR  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'b000,
        IMM_U    = 3'b001,
        IMM_J    = 3'b010,
        IMM_S    = 3'b011,
        IMM_I    = 3'b100,
        IMM_B    = 3'b101
    } imm_type_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_IMM   = 2'b01,
        PC_ALU   = 2'b10,
        PC_HOLD  = 2'b11
    } pc_sel_t;

    typedef enum logic [1:0] {
        RD_ALU = 2'b00,
        RD_MEM = 2'b01,
        RD_PC4 = 2'b10,
        RD_IMM = 2'b11
    } rd_sel_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } ctrl_state_t;

    // The alternate bit only turns ADD into SUB for register-register forms,
    // because OP_IMM has no SUBI and func7 there is part of the immediate.
    function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt,
                                         input logic is_reg);
        alu_op_t op;
        case (f3)
            F3_ADD_SUB: op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_dec.sv
// Purely combinational opcode/func decode into the datapath selects that do
// not depend on the sequencing state.
module ctrl_dec
    import ctrl_pkg::*;
(
    input  logic [4:0] opcode_i,
    input  logic [2:0] func3_i,
    input  logic       func7_alt_i,
    output imm_type_t  imm_type_o,
    output alu_op_t    alu_op_o,
    output logic       alu1_sel_o,
    output logic       alu2_sel_o,
    output logic [2:0] cmp_op_o,
    output rd_sel_t    rd_sel_o,
    output logic       is_legal_o
);

    always_comb begin
        imm_type_o = IMM_NONE;
        alu_op_o   = ALU_ADD;
        alu1_sel_o = 1'b0;
        alu2_sel_o = 1'b0;
        cmp_op_o   = 3'b000;
        rd_sel_o   = RD_ALU;
        is_legal_o = 1'b1;
        case (opcode_i)
            OPC_OP: begin
                alu_op_o = arith_op(func3_i, func7_alt_i, 1'b1);
            end
            OPC_OP_IMM: begin
                imm_type_o = IMM_I;
                alu2_sel_o = 1'b1;
                alu_op_o   = arith_op(func3_i, func7_alt_i, 1'b0);
            end
            OPC_LOAD: begin
                imm_type_o = IMM_I;
                alu2_sel_o = 1'b1;
                rd_sel_o   = RD_MEM;
            end
            OPC_STORE: begin
                imm_type_o = IMM_S;
                alu2_sel_o = 1'b1;
            end
            OPC_LUI: begin
                imm_type_o = IMM_U;
                alu2_sel_o = 1'b1;
                rd_sel_o   = RD_IMM;
            end
            OPC_AUIPC: begin
                imm_type_o = IMM_U;
                alu1_sel_o = 1'b1;
                alu2_sel_o = 1'b1;
            end
            OPC_JAL: begin
                imm_type_o = IMM_J;
                alu1_sel_o = 1'b1;
                alu2_sel_o = 1'b1;
                rd_sel_o   = RD_PC4;
            end
            OPC_JALR: begin
                imm_type_o = IMM_I;
                alu2_sel_o = 1'b1;
                rd_sel_o   = RD_PC4;
            end
            OPC_BRANCH: begin
                imm_type_o = IMM_B;
                cmp_op_o   = func3_i;
            end
            default: is_legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_mc.sv
// Multi-cycle control unit: FETCH/EXEC/MEM/WB/TRAP sequencing, data-memory
// wait timeout and per-state gating of the decoded datapath selects.
module ctrl_mc
    import ctrl_pkg::*;
#(
    parameter int TO_W    = 4,
    parameter int TO_MAX  = 15,
    parameter int EN_TRAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       b,
    input  logic       mem_ack,
    output logic [2:0] imm_type,
    output logic [1:0] inst_sel,
    output logic       reg_wr,
    output logic [3:0] alu_op,
    output logic [2:0] cmp_op,
    output logic [1:0] pc_sel,
    output logic       mem_sel,
    output logic [1:0] rd_sel,
    output logic       alu1_sel,
    output logic       alu2_sel,
    output logic [2:0] sel_type,
    output logic       we,
    output logic       mem_req,
    output logic       trap
);

    ctrl_state_t     state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            fault_q, fault_d;

    imm_type_t  dec_imm;
    alu_op_t    dec_alu;
    logic       dec_alu1, dec_alu2, dec_legal;
    logic [2:0] dec_cmp;
    rd_sel_t    dec_rd;

    logic unused_func7;
    assign unused_func7 = ^{func7[6], func7[4:0]};

    ctrl_dec u_dec (
        .opcode_i    (opcode),
        .func3_i     (func3),
        .func7_alt_i (func7[F7_ALT_BIT]),
        .imm_type_o  (dec_imm),
        .alu_op_o    (dec_alu),
        .alu1_sel_o  (dec_alu1),
        .alu2_sel_o  (dec_alu2),
        .cmp_op_o    (dec_cmp),
        .rd_sel_o    (dec_rd),
        .is_legal_o  (dec_legal)
    );

    logic is_mem, is_store, writes_rd, timeout_hit;
    assign is_store    = (opcode == OPC_STORE);
    assign is_mem      = (opcode == OPC_LOAD) || is_store;
    assign writes_rd   = dec_legal && !is_store && (opcode != OPC_BRANCH);
    assign timeout_hit = (cnt_q == TO_W'(TO_MAX - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // fault_q marks an instruction that is being retired as a NOP because
    // trapping is disabled; it suppresses the register write in WB.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_EXEC;
                cnt_d   = '0;
                fault_d = 1'b0;
            end
            ST_EXEC: begin
                if (!dec_legal) begin
                    if (EN_TRAP != 0) begin
                        state_d = ST_TRAP;
                    end else begin
                        state_d = ST_WB;
                        fault_d = 1'b1;
                    end
                end else if (is_mem) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    cnt_d   = '0;
                    state_d = ST_WB;
                end else if (timeout_hit) begin
                    cnt_d = '0;
                    if (EN_TRAP != 0) begin
                        state_d = ST_TRAP;
                    end else begin
                        state_d = ST_WB;
                        fault_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // Reset gates the outputs directly so an access in flight is dropped
    // immediately rather than at the next clock edge.
    always_comb begin
        imm_type = IMM_NONE;
        inst_sel = INST_HOLD;
        reg_wr   = 1'b0;
        alu_op   = ALU_ADD;
        cmp_op   = 3'b000;
        pc_sel   = PC_HOLD;
        mem_sel  = 1'b0;
        rd_sel   = RD_ALU;
        alu1_sel = 1'b0;
        alu2_sel = 1'b0;
        sel_type = 3'b000;
        we       = 1'b0;
        mem_req  = 1'b0;
        trap     = 1'b0;
        if (rst) begin
            if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
                imm_type = dec_imm;
                alu_op   = dec_alu;
                cmp_op   = dec_cmp;
                alu1_sel = dec_alu1;
                alu2_sel = dec_alu2;
            end
            case (state_q)
                ST_FETCH: inst_sel = INST_LOAD;
                ST_MEM: begin
                    mem_req  = 1'b1;
                    mem_sel  = 1'b1;
                    we       = is_store;
                    sel_type = func3;
                end
                ST_WB: begin
                    rd_sel = dec_rd;
                    reg_wr = writes_rd && !fault_q;
                    if (opcode == OPC_JAL)
                        pc_sel = PC_IMM;
                    else if (opcode == OPC_BRANCH)
                        pc_sel = b ? PC_IMM : PC_PLUS4;
                    else if (opcode == OPC_JALR)
                        pc_sel = PC_ALU;
                    else
                        pc_sel = PC_PLUS4;
                end
                ST_TRAP: begin
                    trap     = 1'b1;
                    inst_sel = INST_NOP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_mc.sv
// Bench for ctrl_mc: directed vector table, randomized instructions against a
// phase-sequence reference model, and reset/timeout/illegal corner sequences.
module tb_ctrl_mc;

    localparam logic [4:0] O_OP     = 5'b01100;
    localparam logic [4:0] O_OPIMM  = 5'b00100;
    localparam logic [4:0] O_LOAD   = 5'b00000;
    localparam logic [4:0] O_STORE  = 5'b01000;
    localparam logic [4:0] O_LUI    = 5'b01101;
    localparam logic [4:0] O_AUIPC  = 5'b00101;
    localparam logic [4:0] O_JAL    = 5'b11011;
    localparam logic [4:0] O_JALR   = 5'b11001;
    localparam logic [4:0] O_BRANCH = 5'b11000;
    localparam logic [4:0] O_ILL    = 5'b10101;

    localparam int PH_FETCH = 0;
    localparam int PH_EXEC  = 1;
    localparam int PH_MEM   = 2;
    localparam int PH_WB    = 3;
    localparam int PH_TRAP  = 4;
    localparam int PH_RESET = 5;

    typedef struct packed {
        logic [2:0] imm;
        logic [1:0] inst;
        logic       regWr;
        logic [3:0] alu;
        logic [2:0] cmp;
        logic [1:0] pc;
        logic       memSel;
        logic [1:0] rd;
        logic       a1;
        logic       a2;
        logic [2:0] selT;
        logic       we;
        logic       req;
        logic       trap;
    } outv_t;

    typedef struct {
        logic [4:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       b;
        int         ack;
        logic [3:0] expAlu;
        logic       expA2;
        logic       expRegWr;
        logic [1:0] expPc;
        logic [1:0] expRd;
        int         expMemCyc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstA, rstB;
    logic [4:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       b, mem_ack;
    outv_t      outA, outB;

    ctrl_mc #(.TO_W(4), .TO_MAX(15), .EN_TRAP(1)) dutA (
        .clk(clk), .rst(rstA), .opcode(opcode), .func3(func3), .func7(func7),
        .b(b), .mem_ack(mem_ack),
        .imm_type(outA.imm), .inst_sel(outA.inst), .reg_wr(outA.regWr),
        .alu_op(outA.alu), .cmp_op(outA.cmp), .pc_sel(outA.pc),
        .mem_sel(outA.memSel), .rd_sel(outA.rd), .alu1_sel(outA.a1),
        .alu2_sel(outA.a2), .sel_type(outA.selT), .we(outA.we),
        .mem_req(outA.req), .trap(outA.trap)
    );

    ctrl_mc #(.TO_W(2), .TO_MAX(3), .EN_TRAP(0)) dutB (
        .clk(clk), .rst(rstB), .opcode(opcode), .func3(func3), .func7(func7),
        .b(b), .mem_ack(mem_ack),
        .imm_type(outB.imm), .inst_sel(outB.inst), .reg_wr(outB.regWr),
        .alu_op(outB.alu), .cmp_op(outB.cmp), .pc_sel(outB.pc),
        .mem_sel(outB.memSel), .rd_sel(outB.rd), .alu1_sel(outB.a1),
        .alu2_sel(outB.a2), .sel_type(outB.selT), .we(outB.we),
        .mem_req(outB.req), .trap(outB.trap)
    );

    int    total = 0;
    int    bad = 0;
    outv_t capExec, capWb;
    int    memCyc;
    vec_t  vecs[15];

    task automatic checkOutput(input string name, input outv_t act, input outv_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic bit isLegal(input logic [4:0] op);
        return op inside {O_OP, O_OPIMM, O_LOAD, O_STORE, O_LUI, O_AUIPC,
                          O_JAL, O_JALR, O_BRANCH};
    endfunction

    function automatic logic [3:0] aluOf(input logic [2:0] f3, input logic alt,
                                         input logic isReg);
        case (f3)
            3'd0:    return (alt && isReg) ? 4'd1 : 4'd0;
            3'd1:    return 4'd5;
            3'd2:    return 4'd8;
            3'd3:    return 4'd9;
            3'd4:    return 4'd2;
            3'd5:    return alt ? 4'd7 : 4'd6;
            3'd6:    return 4'd3;
            default: return 4'd4;
        endcase
    endfunction

    // Expected outputs for one cycle of an instruction, by phase.
    function automatic outv_t model(input int ph, input logic [4:0] op,
                                    input logic [2:0] f3, input logic [6:0] f7,
                                    input logic br, input bit fault);
        outv_t o = '0;
        o.pc = 2'b11;
        if (ph == PH_FETCH) o.inst = 2'b01;
        if (ph == PH_TRAP) begin
            o.trap = 1'b1;
            o.inst = 2'b10;
        end
        if (ph == PH_EXEC || ph == PH_MEM || ph == PH_WB) begin
            case (op)
                O_OP:     o.alu = aluOf(f3, f7[5], 1'b1);
                O_OPIMM:  begin o.imm = 3'b100; o.a2 = 1'b1; o.alu = aluOf(f3, f7[5], 1'b0); end
                O_LOAD:   begin o.imm = 3'b100; o.a2 = 1'b1; end
                O_STORE:  begin o.imm = 3'b011; o.a2 = 1'b1; end
                O_LUI:    begin o.imm = 3'b001; o.a2 = 1'b1; end
                O_AUIPC:  begin o.imm = 3'b001; o.a1 = 1'b1; o.a2 = 1'b1; end
                O_JAL:    begin o.imm = 3'b010; o.a1 = 1'b1; o.a2 = 1'b1; end
                O_JALR:   begin o.imm = 3'b100; o.a2 = 1'b1; end
                O_BRANCH: begin o.imm = 3'b101; o.cmp = f3; end
                default:  ;
            endcase
        end
        if (ph == PH_MEM) begin
            o.memSel = 1'b1;
            o.req    = 1'b1;
            o.we     = (op == O_STORE);
            o.selT   = f3;
        end
        if (ph == PH_WB) begin
            o.regWr = isLegal(op) && op != O_STORE && op != O_BRANCH && !fault;
            o.rd = (op == O_LOAD) ? 2'b01 :
                   (op == O_JAL || op == O_JALR) ? 2'b10 :
                   (op == O_LUI) ? 2'b11 : 2'b00;
            o.pc = (op == O_JAL) ? 2'b01 :
                   (op == O_BRANCH) ? (br ? 2'b01 : 2'b00) :
                   (op == O_JALR) ? 2'b10 : 2'b00;
        end
        return o;
    endfunction

    // Called at a falling edge with the DUT in FETCH; walks the expected phase
    // sequence one cycle at a time. stopAfter>0 abandons the walk at that cycle.
    task automatic applyStimulus(input bit useB, input logic [4:0] op,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic br, input int ack, input int stopAfter);
        int    ph[$];
        bit    faultWb = 0;
        bit    enTrap = !useB;
        int    toMax = useB ? 3 : 15;
        int    memIdx = 0;
        outv_t act;
        ph.push_back(PH_FETCH);
        ph.push_back(PH_EXEC);
        if (!isLegal(op)) begin
            if (enTrap) begin ph.push_back(PH_TRAP); ph.push_back(PH_TRAP); end
            else begin ph.push_back(PH_WB); faultWb = 1; end
        end else if (op == O_LOAD || op == O_STORE) begin
            for (int k = 0; k < ((ack < toMax) ? ack + 1 : toMax); k++)
                ph.push_back(PH_MEM);
            if (ack < toMax) ph.push_back(PH_WB);
            else if (enTrap) begin ph.push_back(PH_TRAP); ph.push_back(PH_TRAP); end
            else begin ph.push_back(PH_WB); faultWb = 1; end
        end else begin
            ph.push_back(PH_WB);
        end
        opcode = op; func3 = f3; func7 = f7; b = br;
        memCyc = 0;
        for (int i = 0; i < ph.size(); i++) begin
            if (stopAfter > 0 && i == stopAfter) break;
            mem_ack = (ph[i] == PH_MEM) && (memIdx == ack);
            #1;
            act = useB ? outB : outA;
            checkOutput($sformatf("op%b_cyc%0d_ph%0d", op, i, ph[i]), act,
                        model(ph[i], op, f3, f7, br, faultWb));
            if (ph[i] == PH_EXEC) capExec = act;
            if (ph[i] == PH_WB) capWb = act;
            if (act.req) memCyc++;
            if (ph[i] == PH_MEM) memIdx++;
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    // Asserts reset mid-cycle, checks the outputs clear at once, releases it
    // on the next falling edge so the DUT is in FETCH for the next call.
    task automatic pulseReset(input bit useB, input string name);
        #2;
        if (useB) rstB = 1'b0; else rstA = 1'b0;
        #1;
        checkOutput(name, useB ? outB : outA, model(PH_RESET, 5'd0, 3'd0, 7'd0, 1'b0, 0));
        @(negedge clk);
        if (useB) rstB = 1'b1; else rstA = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{O_OP,     3'b000, 7'b0100000, 1'b0, 0,  4'b0001, 1'b0, 1'b1, 2'b00, 2'b00, 0};
        vecs[1]  = '{O_OPIMM,  3'b101, 7'b0100000, 1'b0, 0,  4'b0111, 1'b1, 1'b1, 2'b00, 2'b00, 0};
        vecs[2]  = '{O_OPIMM,  3'b000, 7'b0100000, 1'b0, 0,  4'b0000, 1'b1, 1'b1, 2'b00, 2'b00, 0};
        vecs[3]  = '{O_STORE,  3'b010, 7'b0000000, 1'b0, 3,  4'b0000, 1'b1, 1'b0, 2'b00, 2'b00, 4};
        vecs[4]  = '{O_BRANCH, 3'b001, 7'b0000000, 1'b1, 0,  4'b0000, 1'b0, 1'b0, 2'b01, 2'b00, 0};
        vecs[5]  = '{O_BRANCH, 3'b100, 7'b0000000, 1'b0, 0,  4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 0};
        vecs[6]  = '{O_JALR,   3'b000, 7'b0000000, 1'b0, 0,  4'b0000, 1'b1, 1'b1, 2'b10, 2'b10, 0};
        vecs[7]  = '{O_LOAD,   3'b100, 7'b0000000, 1'b0, 0,  4'b0000, 1'b1, 1'b1, 2'b00, 2'b01, 1};
        vecs[8]  = '{O_LUI,    3'b000, 7'b0000000, 1'b0, 0,  4'b0000, 1'b1, 1'b1, 2'b00, 2'b11, 0};
        vecs[9]  = '{O_JAL,    3'b000, 7'b0000000, 1'b0, 0,  4'b0000, 1'b1, 1'b1, 2'b01, 2'b10, 0};
        vecs[10] = '{O_OP,     3'b101, 7'b0100000, 1'b0, 0,  4'b0111, 1'b0, 1'b1, 2'b00, 2'b00, 0};
        vecs[11] = '{O_OP,     3'b011, 7'b0000000, 1'b0, 0,  4'b1001, 1'b0, 1'b1, 2'b00, 2'b00, 0};
        vecs[12] = '{O_AUIPC,  3'b000, 7'b0000000, 1'b0, 0,  4'b0000, 1'b1, 1'b1, 2'b00, 2'b00, 0};
        vecs[13] = '{O_LOAD,   3'b010, 7'b0000000, 1'b0, 14, 4'b0000, 1'b1, 1'b1, 2'b00, 2'b01, 15};
        vecs[14] = '{O_OP,     3'b010, 7'b0000000, 1'b0, 0,  4'b1000, 1'b0, 1'b1, 2'b00, 2'b00, 0};

        rstA = 1'b0; rstB = 1'b0;
        opcode = '0; func3 = '0; func7 = '0; b = 1'b0; mem_ack = 1'b0;
        #2;
        checkOutput("reset_A", outA, model(PH_RESET, 5'd0, 3'd0, 7'd0, 1'b0, 0));
        checkOutput("reset_B", outB, model(PH_RESET, 5'd0, 3'd0, 7'd0, 1'b0, 0));
        @(negedge clk);
        rstA = 1'b1;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].b, vecs[i].ack, 0);
            checkValue($sformatf("vec%0d_alu", i), int'(capExec.alu), int'(vecs[i].expAlu));
            checkValue($sformatf("vec%0d_alu2", i), int'(capExec.a2), int'(vecs[i].expA2));
            checkValue($sformatf("vec%0d_regwr", i), int'(capWb.regWr), int'(vecs[i].expRegWr));
            checkValue($sformatf("vec%0d_pcsel", i), int'(capWb.pc), int'(vecs[i].expPc));
            checkValue($sformatf("vec%0d_rdsel", i), int'(capWb.rd), int'(vecs[i].expRd));
            checkValue($sformatf("vec%0d_memcyc", i), memCyc, vecs[i].expMemCyc);
        end

        for (int n = 0; n < 30; n++) begin
            logic [4:0] ops[9];
            ops = '{O_OP, O_OPIMM, O_LOAD, O_STORE, O_LUI, O_AUIPC, O_JAL, O_JALR, O_BRANCH};
            applyStimulus(0, ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
                          7'($urandom_range(0, 1) << 5), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 4)), 0);
        end

        applyStimulus(0, O_LOAD, 3'b010, 7'd0, 1'b0, 15, 0);
        pulseReset(0, "reset_mid_trap");
        applyStimulus(0, O_OP, 3'b100, 7'd0, 1'b0, 0, 0);

        applyStimulus(0, O_ILL, 3'b000, 7'd0, 1'b0, 0, 0);
        pulseReset(0, "reset_after_illegal");

        applyStimulus(0, O_STORE, 3'b001, 7'd0, 1'b0, 10, 4);
        pulseReset(0, "reset_mid_mem");
        applyStimulus(0, O_OPIMM, 3'b110, 7'd0, 1'b0, 0, 0);

        @(negedge clk);
        rstA = 1'b0;
        rstB = 1'b1;
        applyStimulus(1, O_ILL, 3'b000, 7'd0, 1'b0, 0, 0);
        checkValue("notrap_illegal_regwr", int'(capWb.regWr), 0);
        checkValue("notrap_illegal_pcsel", int'(capWb.pc), 0);
        applyStimulus(1, O_LOAD, 3'b000, 7'd0, 1'b0, 5, 0);
        checkValue("notrap_timeout_regwr", int'(capWb.regWr), 0);
        checkValue("notrap_timeout_memcyc", memCyc, 3);
        applyStimulus(1, O_LOAD, 3'b101, 7'd0, 1'b0, 2, 0);
        checkValue("notrap_ack_at_limit_regwr", int'(capWb.regWr), 1);
        applyStimulus(1, O_OP, 3'b000, 7'b0100000, 1'b0, 0, 0);
        checkValue("notrap_after_fault_alu", int'(capExec.alu), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
